// File: rtl/dbf_fine_apod.sv
// Fractional-delay interpolation and apodisation weighting for one beamformer channel.
// Accept-to-output latency is 4 cycles; there is no backpressure, and a sample is taken whenever the accept term is true.
module dbf_fine_apod #(
    parameter int INPUT_WD = 14,
    parameter int APO_WD   = 16,
    parameter int FRAC_WD  = 8,
    parameter int ADDR_WD  = 6,
    parameter int ZONE_LEN = 16,
    parameter int OUT_WD   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] fd_din,
    input  logic                       fd_din_valid,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic                       lut_we,
    input  logic [FRAC_WD-1:0]         lut_din,
    output logic signed [OUT_WD-1:0]   dbf_fd_dout,
    output logic                       dbf_fd_dout_valid,
    output logic [ADDR_WD-1:0]         zone_idx
);

    localparam int D_WD    = INPUT_WD + 1;
    localparam int Y_WD    = INPUT_WD + 2;
    localparam int PROD_WD = D_WD + FRAC_WD + 1;
    localparam int CNT_WD  = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
    localparam logic [CNT_WD-1:0]  CNT_LAST  = CNT_WD'(ZONE_LEN - 1);
    localparam logic [ADDR_WD-1:0] ZONE_LAST = {ADDR_WD{1'b1}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [FRAC_WD-1:0]         r_lut [2**ADDR_WD];

    logic signed [INPUT_WD-1:0] r_prev;
    logic [CNT_WD-1:0]          r_cnt;
    logic [ADDR_WD-1:0]         r_zone;

    logic                       r_s1_vld;
    logic signed [INPUT_WD-1:0] r_s1_x;
    logic signed [D_WD-1:0]     r_s1_d;
    logic [FRAC_WD-1:0]         r_s1_f;
    logic signed [APO_WD-1:0]   r_s1_apo;

    logic                       r_s2_vld;
    logic signed [INPUT_WD-1:0] r_s2_x;
    logic signed [PROD_WD-1:0]  r_s2_prod;
    logic signed [APO_WD-1:0]   r_s2_apo;

    logic                       r_s3_vld;
    logic signed [Y_WD-1:0]     r_s3_y;
    logic signed [APO_WD-1:0]   r_s3_apo;

    logic                       r_s4_vld;
    logic signed [OUT_WD-1:0]   r_s4_prod;

    logic signed [OUT_WD-1:0]   r_dout;
    logic                       r_dout_vld;

    logic                       w_accept;
    logic                       w_clear;
    logic signed [D_WD-1:0]     w_d;
    logic signed [PROD_WD-1:0]  w_prod;
    logic signed [PROD_WD-1:0]  w_rnd;
    logic signed [PROD_WD-1:0]  w_shf;
    logic signed [Y_WD-1:0]     w_y;
    logic signed [OUT_WD-1:0]   w_out;

    assign w_accept = start & fd_din_valid & ~tx_en & (r_state == S_RUN);
    // Dropping start flushes everything in flight and rewinds the zone tracking.
    assign w_clear  = ~start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (!start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Written from any state and not cleared by reset; the read below sees the pre-write value.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            r_lut[lut_addr] <= lut_din;
        end
    end

    assign w_d    = D_WD'(r_prev) - D_WD'(fd_din);
    assign w_prod = PROD_WD'(r_s1_d) * PROD_WD'($signed({1'b0, r_s1_f}));
    assign w_rnd  = r_s2_prod + PROD_WD'(1 << (FRAC_WD - 1));
    assign w_shf  = w_rnd >>> FRAC_WD;
    assign w_y    = Y_WD'(PROD_WD'(r_s2_x) + w_shf);
    assign w_out  = OUT_WD'(r_s3_y) * OUT_WD'(r_s3_apo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_cnt      <= '0;
            r_zone     <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_d     <= '0;
            r_s1_f     <= '0;
            r_s1_apo   <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_x     <= '0;
            r_s2_prod  <= '0;
            r_s2_apo   <= '0;
            r_s3_vld   <= 1'b0;
            r_s3_y     <= '0;
            r_s3_apo   <= '0;
            r_s4_vld   <= 1'b0;
            r_s4_prod  <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else if (w_clear) begin
            r_prev     <= '0;
            r_cnt      <= '0;
            r_zone     <= '0;
            r_s1_vld   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s3_vld   <= 1'b0;
            r_s4_vld   <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_x   <= fd_din;
                r_s1_d   <= w_d;
                r_s1_f   <= r_lut[r_zone];
                r_s1_apo <= apo_din;
                r_prev   <= fd_din;
                if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
                    if (r_zone != ZONE_LAST) begin
                        r_zone <= r_zone + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            r_s2_vld   <= r_s1_vld;
            r_s2_x     <= r_s1_x;
            r_s2_prod  <= w_prod;
            r_s2_apo   <= r_s1_apo;

            r_s3_vld   <= r_s2_vld;
            r_s3_y     <= w_y;
            r_s3_apo   <= r_s2_apo;

            r_s4_vld   <= r_s3_vld;
            r_s4_prod  <= w_out;

            r_dout_vld <= r_s4_vld;
            r_dout     <= r_s4_vld ? r_s4_prod : '0;
        end
    end

    assign dbf_fd_dout       = r_dout;
    assign dbf_fd_dout_valid = r_dout_vld;
    assign zone_idx          = r_zone;

endmodule

// File: tb/tb_dbf_fine_apod.sv
// Directed and randomized bench for dbf_fine_apod against an arithmetic reference model.
module tb_dbf_fine_apod;

    localparam int INPUT_WD = 14;
    localparam int APO_WD   = 16;
    localparam int FRAC_WD  = 8;
    localparam int ADDR_WD  = 6;
    localparam int ZONE_LEN = 16;
    localparam int OUT_WD   = 32;
    localparam int NZONE    = 1 << ADDR_WD;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       tx_en = 1'b0;
    logic                       start = 1'b0;
    logic signed [INPUT_WD-1:0] fd_din = '0;
    logic                       fd_din_valid = 1'b0;
    logic signed [APO_WD-1:0]   apo_din = '0;
    logic [ADDR_WD-1:0]         lut_addr = '0;
    logic                       lut_we = 1'b0;
    logic [FRAC_WD-1:0]         lut_din = '0;
    logic signed [OUT_WD-1:0]   dbf_fd_dout;
    logic                       dbf_fd_dout_valid;
    logic [ADDR_WD-1:0]         zone_idx;

    dbf_fine_apod #(
        .INPUT_WD(INPUT_WD), .APO_WD(APO_WD), .FRAC_WD(FRAC_WD),
        .ADDR_WD(ADDR_WD), .ZONE_LEN(ZONE_LEN), .OUT_WD(OUT_WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .fd_din(fd_din), .fd_din_valid(fd_din_valid), .apo_din(apo_din),
        .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
        .dbf_fd_dout(dbf_fd_dout), .dbf_fd_dout_valid(dbf_fd_dout_valid),
        .zone_idx(zone_idx)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int val; } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_lut [NZONE];
    bit   m_run = 1'b0;
    int   m_p = 0;
    int   m_nacc = 0;
    exp_t q [$];
    int   obs [$];

    function automatic int ref_out(int x, int p, int f, int apo);
        int t;
        int y;
        t = (p - x) * f + (1 << (FRAC_WD - 1));
        y = x + (t >>> FRAC_WD);
        return y * apo;
    endfunction

    function automatic int zone_of(int nacc);
        int z;
        z = nacc / ZONE_LEN;
        return (z > NZONE - 1) ? NZONE - 1 : z;
    endfunction

    task automatic check_outputs(string tag);
        bit ev;
        int eval;
        ev = 1'b0;
        eval = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1'b1;
            eval = q[0].val;
            void'(q.pop_front());
        end
        checks++;
        assert (dbf_fd_dout_valid === ev) else begin
            errors++;
            $error("FAIL %s valid cyc=%0d got %0b exp %0b", tag, cyc, dbf_fd_dout_valid, ev);
        end
        checks++;
        assert (dbf_fd_dout === 32'(eval)) else begin
            errors++;
            $error("FAIL %s dout cyc=%0d got %0d exp %0d", tag, cyc, dbf_fd_dout, eval);
        end
        checks++;
        assert (zone_idx === 6'(zone_of(m_nacc))) else begin
            errors++;
            $error("FAIL %s zone cyc=%0d got %0d exp %0d", tag, cyc, zone_idx, zone_of(m_nacc));
        end
    endtask

    task automatic step(string tag, bit st, bit tx, bit v, int x, int apo,
                        bit we = 1'b0, int wa = 0, int wd = 0);
        start        = st;
        tx_en        = tx;
        fd_din_valid = v;
        fd_din       = 14'(x);
        apo_din      = 16'(apo);
        lut_we       = we;
        lut_addr     = 6'(wa);
        lut_din      = 8'(wd);
        cyc++;
        if (m_run && st && v && !tx) begin
            q.push_back('{cyc + 4, ref_out(x, m_p, m_lut[zone_of(m_nacc)], apo)});
            m_p = x;
            m_nacc++;
        end
        if (we) m_lut[wa] = wd;
        if (!st) begin
            m_run = 1'b0;
            q.delete();
            m_p = 0;
            m_nacc = 0;
        end else begin
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        if (dbf_fd_dout_valid) obs.push_back(int'(dbf_fd_dout));
        check_outputs(tag);
    endtask

    task automatic chk_obs(string tag, int idx, int exp);
        int got;
        got = (idx < obs.size()) ? obs[idx] : 32'h7fffffff;
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s out[%0d] got %0d exp %0d", tag, idx, got, exp);
        end
    endtask

    task automatic chk_cnt(string tag, int n);
        checks++;
        assert (obs.size() == n) else begin
            errors++;
            $error("FAIL %s count got %0d exp %0d", tag, obs.size(), n);
        end
    endtask

    task automatic idle(string tag, bit st, int n);
        for (int i = 0; i < n; i++) step(tag, st, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic rand_step(string tag, int drop_pct);
        bit st;
        st = ($urandom_range(0, 99) < drop_pct) ? 1'b0 : 1'b1;
        step(tag, st, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80,
             int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 65535)) - 32768,
             $urandom_range(0, 99) < 5, int'($urandom_range(0, NZONE - 1)),
             int'($urandom_range(0, 255)));
    endtask

    initial begin
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NZONE; i++) step("lutinit", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, i, 0);

        obs.delete();
        step("byp", 1'b1, 1'b0, 1'b1, 999, 1);
        step("byp", 1'b1, 1'b0, 1'b1, 100, 1);
        step("byp", 1'b1, 1'b0, 1'b1, 200, 1);
        step("byp", 1'b1, 1'b0, 1'b1, 300, 1);
        idle("byp", 1'b1, 5);
        chk_cnt("byp", 3);
        chk_obs("byp", 0, 100);
        chk_obs("byp", 1, 200);
        chk_obs("byp", 2, 300);
        step("byp", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 128);

        obs.delete();
        step("half", 1'b1, 1'b0, 1'b0, 0, 0);
        step("half", 1'b1, 1'b0, 1'b1, 100, 2);
        step("half", 1'b1, 1'b0, 1'b1, 200, 2);
        idle("half", 1'b1, 5);
        chk_obs("half", 0, 100);
        chk_obs("half", 1, 300);
        step("half", 1'b0, 1'b0, 1'b0, 0, 0);
        obs.delete();
        step("halfn", 1'b1, 1'b0, 1'b0, 0, 0);
        step("halfn", 1'b1, 1'b0, 1'b1, 100, -3);
        step("halfn", 1'b1, 1'b0, 1'b1, 200, -3);
        idle("halfn", 1'b1, 5);
        chk_obs("halfn", 0, -150);
        chk_obs("halfn", 1, -450);
        step("halfn", 1'b0, 1'b0, 1'b0, 0, 0);

        obs.delete();
        step("gap", 1'b1, 1'b0, 1'b0, 0, 0);
        step("gap", 1'b1, 1'b0, 1'b1, 100, 1);
        step("gap", 1'b1, 1'b1, 1'b1, 555, 1);
        step("gap", 1'b1, 1'b0, 1'b0, 777, 1);
        step("gap", 1'b1, 1'b0, 1'b1, 200, 1);
        idle("gap", 1'b1, 5);
        chk_cnt("gap", 2);
        chk_obs("gap", 0, 50);
        chk_obs("gap", 1, 150);

        step("zone", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
        step("zone", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1, 64);
        step("zone", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 17; i++)
            step("zone", 1'b1, 1'b0, 1'b1, int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 65535)) - 32768);
        idle("zone", 1'b1, 5);

        step("drop", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 128);
        step("drop", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step("drop", 1'b1, 1'b0, 1'b1, 1000 * (i + 1), 7);
        idle("drop", 1'b1, 1);
        idle("drop", 1'b0, 6);
        obs.delete();
        step("restart", 1'b1, 1'b0, 1'b0, 0, 0);
        step("restart", 1'b1, 1'b0, 1'b1, 100, 1);
        idle("restart", 1'b1, 5);
        chk_cnt("restart", 1);
        chk_obs("restart", 0, 50);
        step("restart", 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < NZONE; i++)
            step("lutrnd", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, i, int'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) rand_step("rnddrop", 3);
        step("sat", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 1800; i++) rand_step("sat", 0);
        checks++;
        assert (zone_idx === 6'(NZONE - 1)) else begin
            errors++;
            $error("FAIL sat_zone got %0d exp %0d", zone_idx, NZONE - 1);
        end

        rst_n = 1'b0;
        #1;
        m_run = 1'b0;
        q.delete();
        m_p = 0;
        m_nacc = 0;
        check_outputs("areset");
        #1;
        rst_n = 1'b1;
        step("post", 1'b1, 1'b0, 1'b1, 100, 1);
        for (int i = 0; i < 20; i++) rand_step("post", 0);
        idle("post", 1'b1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
